fire_sequencer: RTL

FIRE_SEQUENCER -- requirements
Module: fire_sequencer

---
 rtl/fire_sequencer_pkg.sv | 9 +
 rtl/fire_beat_lut.sv | 9 +
 rtl/fire_sequencer.sv | 72 +++++++
 3 files changed

// File: rtl/fire_sequencer_pkg.sv
// fire_sequencer_pkg: FSM states, counter width and per-fire expected beat counts.
package fire_sequencer_pkg;
  localparam int BEAT_W = 16;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SQUEEZE, S_WAIT_EXP, S_FIN} state_t;
  localparam logic [7:0][BEAT_W-1:0] EXP_BEATS = {
    16'd1352, 16'd1352, 16'd1014, 16'd1014,
    16'd2916, 16'd2916, 16'd6050, 16'd6050
  };
endpackage

// File: rtl/fire_beat_lut.sv
// fire_beat_lut: expected squeeze output beats (inputsize^2*filtersize/8) for a fire config.
module fire_beat_lut
  import fire_sequencer_pkg::*;
(
  input  logic [2:0]        i_firesel,
  output logic [BEAT_W-1:0] o_beats
);
  assign o_beats = EXP_BEATS[i_firesel];
endmodule

// File: rtl/fire_sequencer.sv
// fire_sequencer: steps fire configs first..last, gating squeeze beats and expand handoff.
module fire_sequencer
  import fire_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        first_fire,
  input  logic [2:0]        last_fire,
  input  logic              sq_outvalid,
  input  logic              exp_done,
  output logic [2:0]        firesel,
  output logic              sq_data_valid,
  output logic              pingpong_sel,
  output logic              busy,
  output logic              done,
  output logic [BEAT_W-1:0] beat_cnt,
  output logic              err_overrun
);
  state_t            r_state, w_state_nx;
  logic [2:0]        r_firesel, r_last;
  logic              r_pp, r_err;
  logic [BEAT_W-1:0] r_beat, w_exp;
  logic              w_last_beat;
  fire_beat_lut u_lut (
    .i_firesel (r_firesel),
    .o_beats   (w_exp)
  );
  assign w_last_beat = sq_outvalid && (r_beat == w_exp - 16'd1);
  always_comb begin
    w_state_nx    = r_state;
    sq_data_valid = r_state == S_SQUEEZE;
    busy          = r_state inside {S_LOAD, S_SQUEEZE, S_WAIT_EXP};
    done          = r_state == S_FIN;
    case (r_state)
      S_IDLE:     w_state_nx = start ? S_LOAD : S_IDLE;
      S_LOAD:     w_state_nx = S_SQUEEZE;
      S_SQUEEZE:  w_state_nx = w_last_beat ? S_WAIT_EXP : S_SQUEEZE;
      S_WAIT_EXP: w_state_nx = !exp_done ? S_WAIT_EXP : (r_firesel == r_last ? S_FIN : S_LOAD);
      default:    w_state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_firesel <= '0;
      r_last    <= '0;
      r_pp      <= 1'b0;
      r_beat    <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      if (r_state == S_IDLE && start) begin
        r_firesel <= first_fire;
        r_last    <= last_fire;
        r_pp      <= 1'b0;
      end
      // 3-bit increment wraps 7->0 so a last_fire below first_fire still terminates
      if (r_state == S_WAIT_EXP && exp_done && r_firesel != r_last) begin
        r_firesel <= r_firesel + 3'd1;
        r_pp      <= ~r_pp;
      end
      if (r_state == S_LOAD) r_beat <= '0;
      else if (r_state == S_SQUEEZE && sq_outvalid) r_beat <= r_beat + 16'd1;
      if (sq_outvalid && r_state != S_SQUEEZE) r_err <= 1'b1;
    end
  end
  assign firesel      = r_firesel;
  assign pingpong_sel = r_pp;
  assign beat_cnt     = r_beat;
  assign err_overrun  = r_err;
endmodule
